// File: rtl/pwm_duty_ramp_ctrl.sv
// pwm_duty_ramp_ctrl
// Arbitrates two absolute-duty requesters and steps the PWM generator toward the
// accepted target with one increase/decrease pulse per step. A shadow copy of the
// generator duty is kept locally so the ramp knows when it has arrived.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for a request; ready high (except in the done cycle)
// S_CHECK  | compare shadow duty to target, start a step or finish
// S_HI     | step pulse held high for PULSE_LEN cycles
// S_LO     | both pulses low for PULSE_LEN cycles before the next check
module pwm_duty_ramp_ctrl #(
    parameter int DUTY_W    = 4,
    parameter int MAX_DUTY  = 10,
    parameter int INIT_DUTY = 5,
    parameter int PULSE_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [DUTY_W-1:0] req_target0,
    input  logic [DUTY_W-1:0] req_target1,
    output logic [1:0]        req_ack,
    output logic              ready,
    output logic              increase_duty,
    output logic              decrease_duty,
    output logic [DUTY_W-1:0] cur_duty,
    output logic              done,
    output logic              owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_HI    = 2'd2;
    localparam logic [1:0] S_LO    = 2'd3;

    localparam int CNT_W = (PULSE_LEN > 2) ? $clog2(PULSE_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [DUTY_W-1:0] MAX_D    = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0] INIT_D   = DUTY_W'(INIT_DUTY);
    localparam logic [DUTY_W-1:0] ONE_D    = DUTY_W'(1);
    localparam logic [DUTY_W-1:0] ZERO_D   = '0;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DUTY_W-1:0] target;
    logic              rr_ptr;
    logic [1:0]        gnt;
    logic [DUTY_W-1:0] sel_target;
    logic [DUTY_W-1:0] clip_target;

    // The done cycle is spent in IDLE but withholds ready so done and ack never coincide.
    assign ready   = (state == S_IDLE) && !done;
    assign req_ack = gnt;

    // Combinational grant: lone requester wins, contention resolved by the RR pointer.
    always_comb begin
        gnt = 2'b00;
        if (ready) begin
            case (req_valid)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Selected target, clipped to the highest legal duty.
    always_comb begin
        sel_target  = gnt[1] ? req_target1 : req_target0;
        clip_target = (sel_target > MAX_D) ? MAX_D : sel_target;
    end

    // Sequencer: grant, compare, then pulse-high / pulse-low per duty step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= CNT_ZERO;
            target        <= INIT_D;
            rr_ptr        <= 1'b0;
            increase_duty <= 1'b0;
            decrease_duty <= 1'b0;
            cur_duty      <= INIT_D;
            done          <= 1'b0;
            owner         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt != 2'b00) begin
                        target <= clip_target;
                        owner  <= gnt[1];
                        if (req_valid == 2'b11) begin
                            rr_ptr <= ~gnt[1];
                        end
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (cur_duty == target) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        increase_duty <= (target > cur_duty);
                        decrease_duty <= (target < cur_duty);
                        cnt           <= CNT_LAST;
                        state         <= S_HI;
                    end
                end
                S_HI: begin
                    if (cnt == CNT_ZERO) begin
                        if (increase_duty && (cur_duty < MAX_D)) begin
                            cur_duty <= cur_duty + ONE_D;
                        end else if (decrease_duty && (cur_duty != ZERO_D)) begin
                            cur_duty <= cur_duty - ONE_D;
                        end
                        increase_duty <= 1'b0;
                        decrease_duty <= 1'b0;
                        cnt           <= CNT_LAST;
                        state         <= S_LO;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_LO: begin
                    if (cnt == CNT_ZERO) begin
                        state <= S_CHECK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
